// File: rtl/zx_vram_pkg.sv
// rtl/zx_vram_pkg.sv - shared types and write-address decode for the ULA screen-RAM port
package zx_vram_pkg;

  typedef struct packed {
    logic [14:0] a;
    logic [7:0]  d;
  } vram_wr_t;

  localparam logic [2:0] PAGE_SCR0 = 3'd5;
  localparam logic [2:0] PAGE_SCR1 = 3'd7;

  typedef enum logic [1:0] {IDLE, RD_ADDR, RD_DATA} vram_st_t;

  // Result [15] = write hits screen RAM, [14:0] = screen RAM address ([14] selects page 7).
  function automatic logic [15:0] scr_decode(input logic [15:0] addr, input logic m128,
                                             input logic [2:0] page_ram);
    logic [15:0] r;
    r = '0;
    if (addr[15:14] == 2'b01)
      r = {2'b10, addr[13:0]};
    else if (m128 && addr[15:14] == 2'b11 && page_ram == PAGE_SCR0)
      r = {2'b10, addr[13:0]};
    else if (m128 && addr[15:14] == 2'b11 && page_ram == PAGE_SCR1)
      r = {2'b11, addr[13:0]};
    return r;
  endfunction

endpackage

// File: rtl/vram_wr_fifo.sv
// rtl/vram_wr_fifo.sv - CPU write queue; VRAM_WR_COALESCE_EN merges a push into the newest entry
module vram_wr_fifo import zx_vram_pkg::*; #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic     clk_sys,
  input  logic     reset,
  input  logic     push,
  input  vram_wr_t push_data,
  input  logic     pop,
  output vram_wr_t head,
  output logic     full,
  output logic     empty,
  output logic     merge
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  vram_wr_t        mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            do_pop;
  logic            alloc;

  assign full   = (count == CW'(FIFO_DEPTH));
  assign empty  = (count == '0);
  assign do_pop = pop & ~empty;
  assign head   = mem[rd_ptr];

`ifdef VRAM_WR_COALESCE_EN
  logic [AW-1:0] last_ptr;
  assign last_ptr = wr_ptr - 1'b1;
  // The newest entry is only mergeable if it is not leaving on this same clock.
  assign merge = push & ~empty & (mem[last_ptr].a == push_data.a)
               & ~(do_pop & (count == CW'(1)));
`else
  assign merge = 1'b0;
`endif

  assign alloc = push & ~merge & ~full;

  always_ff @(posedge clk_sys) begin
    if (alloc)
      mem[wr_ptr] <= push_data;
`ifdef VRAM_WR_COALESCE_EN
    if (merge)
      mem[last_ptr].d <= push_data.d;
`endif
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (alloc)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(alloc) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/vram_port.sv
// rtl/vram_port.sv - screen RAM owner: snoops CPU writes into a queue, serves video fetches
// Optional write coalescing in the queue is enabled by VRAM_WR_COALESCE_EN.
module vram_port import zx_vram_pkg::*; #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ce_7mn,
  input  logic [15:0] addr,
  input  logic [7:0]  din,
  input  logic        nMREQ,
  input  logic        nWR,
  input  logic        nRFSH,
  input  logic [2:0]  page_ram,
  input  logic        m128,
  input  logic [14:0] vram_addr,
  output logic [7:0]  vram_dout,
  output logic        wr_overflow
);

  logic        wr_cond;
  logic        wr_cond_q;
  logic [15:0] dec;
  logic        push;
  logic        pop;
  vram_wr_t    push_data;
  vram_wr_t    head;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_merge;
  vram_st_t    state;
  logic [7:0]  ram [32768];
  logic [7:0]  ram_q;

  assign wr_cond   = ~nMREQ & ~nWR & nRFSH;
  assign dec       = scr_decode(addr, m128, page_ram);
  assign push      = wr_cond & ~wr_cond_q & dec[15];
  assign push_data = {dec[14:0], din};
  // The fetch strobe owns the RAM on the clock it arrives, so no drain then.
  assign pop       = (state == IDLE) & ~ce_7mn & ~fifo_empty;

  vram_wr_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .merge     (fifo_merge)
  );

  // Single-port RAM; a write already issued still lands even if reset arrives.
  always_ff @(posedge clk_sys) begin
    if (pop)
      ram[head.a] <= head.d;
    else if (state == RD_ADDR)
      ram_q <= ram[vram_addr];
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state       <= IDLE;
      wr_cond_q   <= 1'b0;
      vram_dout   <= 8'h00;
      wr_overflow <= 1'b0;
    end else begin
      wr_cond_q <= wr_cond;
      if (push & fifo_full & ~fifo_merge)
        wr_overflow <= 1'b1;
      case (state)
        IDLE:    if (ce_7mn) state <= RD_ADDR;
        RD_ADDR: state <= RD_DATA;
        RD_DATA: begin
          vram_dout <= ram_q;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_port.sv
// tb/tb_vram_port.sv - directed bench for vram_port with a queue/array reference model
module tb_vram_port;

  localparam int DEPTH = 4;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ce_7mn = 1'b0;
  logic [15:0] addr = '0;
  logic [7:0]  din = '0;
  logic        nMREQ = 1'b1;
  logic        nWR = 1'b1;
  logic        nRFSH = 1'b1;
  logic [2:0]  page_ram = '0;
  logic        m128 = 1'b0;
  logic [14:0] vram_addr = '0;
  logic [7:0]  vram_dout;
  logic        wr_overflow;

  int checks = 0;
  int errors = 0;
  bit started = 0;

  vram_port #(.FIFO_DEPTH(DEPTH)) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .ce_7mn      (ce_7mn),
    .addr        (addr),
    .din         (din),
    .nMREQ       (nMREQ),
    .nWR         (nWR),
    .nRFSH       (nRFSH),
    .page_ram    (page_ram),
    .m128        (m128),
    .vram_addr   (vram_addr),
    .vram_dout   (vram_dout),
    .wr_overflow (wr_overflow)
  );

  always #5 clk_sys = ~clk_sys;

  // Reference model: queue of pending writes, sparse RAM image, fetch age in clocks.
  typedef struct {
    logic [14:0] a;
    logic [7:0]  d;
  } m_wr_t;

  m_wr_t       m_q[$];
  logic [7:0]  ram_m [int];
  int          m_age = -1;
  bit          m_prev = 0;
  bit          m_ovf = 0;
  bit          m_known = 0;
  logic [7:0]  m_dout = '0;
  bit          rd_known = 0;
  logic [7:0]  rd_val = '0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk_sys) begin
    bit wc, start, hit, slot, merge;
    int n_before;
    logic [14:0] ra;
    m_wr_t e;
    wc    = !nMREQ && !nWR && nRFSH;
    start = wc && !m_prev;
    hit   = 0;
    ra    = '0;
    if (addr[15:14] == 2'b01) begin
      hit = 1; ra = {1'b0, addr[13:0]};
    end else if (m128 && addr[15:14] == 2'b11 && page_ram == 3'd5) begin
      hit = 1; ra = {1'b0, addr[13:0]};
    end else if (m128 && addr[15:14] == 2'b11 && page_ram == 3'd7) begin
      hit = 1; ra = {1'b1, addr[13:0]};
    end
    n_before = m_q.size();
    slot  = (m_age < 0) && !ce_7mn && (n_before > 0);
    merge = 0;
`ifdef VRAM_WR_COALESCE_EN
    if (start && hit && n_before > 0 && m_q[n_before-1].a == ra && !(slot && n_before == 1))
      merge = 1;
`endif
    if (m_age == 1) begin
      m_known = rd_known;
      m_dout  = rd_val;
    end
    if (m_age == 0) begin
      rd_known = ram_m.exists(int'(vram_addr));
      if (rd_known) rd_val = ram_m[int'(vram_addr)];
    end
    if (slot) begin
      e = m_q.pop_front();
      ram_m[int'(e.a)] = e.d;
    end
    if (reset) begin
      m_q.delete();
      m_age = -1; m_prev = 0; m_ovf = 0; m_known = 1; m_dout = '0;
    end else begin
      m_prev = wc;
      if (start && hit) begin
        if (merge) begin
          e = m_q[m_q.size()-1]; e.d = din; m_q[m_q.size()-1] = e;
        end else if (n_before == DEPTH) begin
          m_ovf = 1;
        end else begin
          e.a = ra; e.d = din; m_q.push_back(e);
        end
      end
      if (m_age == 1)      m_age = -1;
      else if (m_age == 0) m_age = 1;
      else if (ce_7mn)     m_age = 0;
    end
  end

  always @(negedge clk_sys) begin
    if (started) begin
      if (m_known) chk("dout_model", int'(vram_dout), int'(m_dout));
      chk("ovf_model", int'(wr_overflow), int'(m_ovf));
      chk("count_model", int'(dut.u_fifo.count), m_q.size());
    end
  end

  // All tasks start just after a negedge and return on a negedge.
  task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d, input logic rfsh_n = 1'b1);
    addr = a; din = d; nMREQ = 1'b0; nWR = 1'b0; nRFSH = rfsh_n;
    @(negedge clk_sys);
    nMREQ = 1'b1; nWR = 1'b1; nRFSH = 1'b1;
    @(negedge clk_sys);
  endtask

  task automatic fetch_chk(input string name, input logic [14:0] a, input logic [7:0] exp);
    vram_addr = a; ce_7mn = 1'b1;
    @(negedge clk_sys);
    ce_7mn = 1'b0;
    @(negedge clk_sys);
    @(negedge clk_sys);
    chk(name, int'(vram_dout), int'(exp));
    @(negedge clk_sys);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic wait_age(input int target);
    bit found;
    found = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      if (m_age == target) found = 1;
      else @(negedge clk_sys);
    end
    chk("wait_fetch_phase", int'(found), 1);
  endtask

  initial begin
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    started = 1;
    chk("reset_dout", int'(vram_dout), 8'h00);
    chk("reset_ovf", int'(wr_overflow), 0);

    cpu_wr(16'h4000, 8'hA5);
    fetch_chk("t1_fetch_0000", 15'h0000, 8'hA5);

    m128 = 1'b1; page_ram = 3'd5;
    cpu_wr(16'hC123, 8'h11);
    page_ram = 3'd7;
    cpu_wr(16'hC123, 8'h3C);
    fetch_chk("t2_page7", 15'h4123, 8'h3C);
    fetch_chk("t2_page5_kept", 15'h0123, 8'h11);
    page_ram = 3'd2;
    cpu_wr(16'hC123, 8'h99);
    fetch_chk("t2_page2_ign7", 15'h4123, 8'h3C);
    fetch_chk("t2_page2_ign5", 15'h0123, 8'h11);
    m128 = 1'b0; page_ram = 3'd7;
    cpu_wr(16'hC123, 8'h55);
    fetch_chk("t2_m128_off", 15'h4123, 8'h3C);

    cpu_wr(16'h4200, 8'h22);
    cpu_wr(16'h4004, 8'h77);
    m128 = 1'b1;
    cpu_wr(16'h8200, 8'h66);
    cpu_wr(16'h0200, 8'h66);
    cpu_wr(16'h4200, 8'h66, 1'b0);
    fetch_chk("t3_ignored", 15'h0200, 8'h22);

    vram_addr = 15'h0200; ce_7mn = 1'b1;
    for (int i = 0; i < 5; i++) cpu_wr(16'h4000 + 16'(i), 8'h10 + 8'(i));
    chk("t4_overflow", int'(wr_overflow), 1);
    ce_7mn = 1'b0;
    idle(8);
    fetch_chk("t4_land0", 15'h0000, 8'h10);
    fetch_chk("t4_land3", 15'h0003, 8'h13);
    fetch_chk("t4_dropped", 15'h0004, 8'h77);
    chk("t4_sticky", int'(wr_overflow), 1);

    vram_addr = 15'h0200; ce_7mn = 1'b1;
    cpu_wr(16'h4010, 8'hA0);
    cpu_wr(16'h4011, 8'hA1);
    cpu_wr(16'h4012, 8'hA2);
    wait_age(-1);
    ce_7mn = 1'b0;
    addr = 16'h4013; din = 8'hA3; nMREQ = 1'b0; nWR = 1'b0;
    @(negedge clk_sys);
    chk("t5_count", int'(dut.u_fifo.count), 3);
    nMREQ = 1'b1; nWR = 1'b1;
    idle(6);
    fetch_chk("t5_order0", 15'h0010, 8'hA0);
    fetch_chk("t5_order3", 15'h0013, 8'hA3);

    vram_addr = 15'h0200; ce_7mn = 1'b1;
    cpu_wr(16'h4010, 8'hB0);
    cpu_wr(16'h4011, 8'hB1);
    cpu_wr(16'h4012, 8'hB2);
    wait_age(0);
    reset = 1'b1; ce_7mn = 1'b0;
    @(negedge clk_sys);
    reset = 1'b0;
    chk("t6_dout", int'(vram_dout), 8'h00);
    chk("t6_ovf", int'(wr_overflow), 0);
    chk("t6_count", int'(dut.u_fifo.count), 0);
    idle(2);
    fetch_chk("t6_discard0", 15'h0010, 8'hA0);
    fetch_chk("t6_discard1", 15'h0011, 8'hA1);
    fetch_chk("t6_normal", 15'h0200, 8'h22);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
